div_ctrl: RTL and testbench

- Multi-cycle sequencer for the RV32M divide/remainder ops (DIV, DIVU, REM, REMU), attached beside the single-cycle exe ALU.
- Accepts one operation from id_exe and holds the pipeline with a stall while it runs a radix-2 restoring divide loop.
- Presents the result to exe_mem for one cycle, using the same waddr/we/wdata triple that exe drives.
- Owns the busy/stall handshake and the abort (flush) handshake for the divide resource.

---
 rtl/div_ctrl_pkg.sv | 22 ++
 rtl/div_step.sv | 26 ++
 rtl/div_ctrl.sv | 150 +++++++++++++++
 tb/tb_div_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared constants and state type for the RV32M divide sequencer.
// No ports; imported by div_ctrl and div_step.
package div_ctrl_pkg;

  localparam int DIV_DW   = 32;
  localparam int DIV_AW   = 5;
  localparam int DIV_ITER = 32;

  localparam logic [2:0] FUN3_DIV  = 3'b100;
  localparam logic [2:0] FUN3_DIVU = 3'b101;
  localparam logic [2:0] FUN3_REM  = 3'b110;
  localparam logic [2:0] FUN3_REMU = 3'b111;

  localparam logic [6:0] FUN7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-divide iteration.
// Ports: i_rem/i_quo/i_dvs in, o_rem/o_quo out (all W bits).
module div_step
  import div_ctrl_pkg::*;
#(
  parameter int W = DIV_DW
) (
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_quo,
  input  logic [W-1:0] i_dvs,
  output logic [W-1:0] o_rem,
  output logic [W-1:0] o_quo
);

  // Shifted partial remainder needs one extra bit for
  // unsigned divisors with the MSB set.
  logic [W:0] w_sh;
  logic       w_ge;

  assign w_sh  = {i_rem, i_quo[W-1]};
  assign w_ge  = w_sh >= {1'b0, i_dvs};
  assign o_rem = w_ge ? (w_sh[W-1:0] - i_dvs)
                      : w_sh[W-1:0];
  assign o_quo = {i_quo[W-2:0], w_ge};

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle DIV/DIVU/REM/REMU sequencer with stall/flush handshake.
// Ports: clk_i, rst_i, start_i, funct3_i, op1_i, op2_i, reg_waddr_i, flush_i -> stall_o, busy_o, reg_we_o, reg_waddr_o, reg_wdata_o.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DIV_DW,
  parameter int RADDR_WIDTH = DIV_AW
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [2:0]             funct3_i,
  input  logic [DATA_WIDTH-1:0]  op1_i,
  input  logic [DATA_WIDTH-1:0]  op2_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   flush_i,
  output logic                   stall_o,
  output logic                   busy_o,
  output logic                   reg_we_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic [DATA_WIDTH-1:0]  reg_wdata_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DIV_ITER);
  localparam logic [CW-1:0] LAST = CW'(DIV_ITER - 1);

  div_state_t             r_state;
  logic [CW-1:0]          r_cnt;
  logic [2:0]             r_funct3;
  logic [RADDR_WIDTH-1:0] r_waddr;
  logic [W-1:0]           r_rem;
  logic [W-1:0]           r_quo;
  logic [W-1:0]           r_dvs;
  logic [W-1:0]           r_res;
  logic                   r_qneg;
  logic                   r_rneg;

  logic         w_signed;
  logic         w_rem_op;
  logic         w_dz;
  logic         w_ovf;
  logic [W-1:0] w_a_abs;
  logic [W-1:0] w_b_abs;
  logic [W-1:0] w_spec;
  logic [W-1:0] w_rem_n;
  logic [W-1:0] w_quo_n;
  logic         w_r_rem;
  logic [W-1:0] w_fin;
  logic         w_wr;

  assign w_signed = (funct3_i == FUN3_DIV)
                  | (funct3_i == FUN3_REM);
  assign w_rem_op = (funct3_i == FUN3_REM)
                  | (funct3_i == FUN3_REMU);

  assign w_a_abs = (w_signed & op1_i[W-1]) ? -op1_i : op1_i;
  assign w_b_abs = (w_signed & op2_i[W-1]) ? -op2_i : op2_i;

  assign w_dz  = op2_i == '0;
  assign w_ovf = w_signed
               & (op1_i == {1'b1, {(W-1){1'b0}}})
               & (op2_i == '1);

  // Results that bypass the iteration loop entirely.
  always_comb begin
    w_spec = '0;
    unique case (1'b1)
      w_dz:     w_spec = w_rem_op ? op1_i : '1;
      w_ovf:    w_spec = w_rem_op ? '0 : op1_i;
      default:  w_spec = '0;
    endcase
  end

  div_step #(.W(W)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_rem_n),
    .o_quo (w_quo_n)
  );

  assign w_r_rem = (r_funct3 == FUN3_REM)
                 | (r_funct3 == FUN3_REMU);
  assign w_fin = w_r_rem
               ? (r_rneg ? -w_rem_n : w_rem_n)
               : (r_qneg ? -w_quo_n : w_quo_n);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= DIV_IDLE;
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_waddr  <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_res    <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
    end else if (flush_i) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        DIV_IDLE: begin
          if (start_i) begin
            r_funct3 <= funct3_i;
            r_waddr  <= reg_waddr_i;
            if (w_dz | w_ovf) begin
              r_res   <= w_spec;
              r_state <= DIV_DONE;
            end else begin
              r_rem   <= '0;
              r_quo   <= w_a_abs;
              r_dvs   <= w_b_abs;
              r_qneg  <= w_signed & (op1_i[W-1] ^ op2_i[W-1]);
              r_rneg  <= w_signed & op1_i[W-1];
              r_cnt   <= '0;
              r_state <= DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          r_rem <= w_rem_n;
          r_quo <= w_quo_n;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_res   <= w_fin;
            r_state <= DIV_DONE;
          end
        end
        DIV_DONE: r_state <= DIV_IDLE;
        default:  r_state <= DIV_IDLE;
      endcase
    end
  end

  // Flush in DONE must kill the write in the same cycle,
  // so the write strobe is gated combinationally.
  assign w_wr = (r_state == DIV_DONE) & ~flush_i;

  assign stall_o = ((r_state == DIV_IDLE) & start_i & ~flush_i)
                 | (r_state == DIV_CALC);
  assign busy_o      = r_state != DIV_IDLE;
  assign reg_we_o    = w_wr;
  assign reg_waddr_o = w_wr ? r_waddr : '0;
  assign reg_wdata_o = w_wr ? r_res : '0;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed + scoreboard bench for div_ctrl.
// Drives ops, queues expected writes, compares on reg_we_o.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  f3;
  logic [31:0] a, b;
  logic [4:0]  wa;
  logic        stall_o, busy_o, reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;
  int wr_cnt = 0;
  int exp_wr = 0;

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .funct3_i    (f3),
    .op1_i       (a),
    .op2_i       (b),
    .reg_waddr_i (wa),
    .flush_i     (flush),
    .stall_o     (stall_o),
    .busy_o      (busy_o),
    .reg_we_o    (reg_we_o),
    .reg_waddr_o (reg_waddr_o),
    .reg_wdata_o (reg_wdata_o)
  );

  always @(negedge clk)
    if (reg_we_o === 1'b1) wr_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  function automatic logic [31:0] model(
    input logic [2:0] fn, input logic [31:0] x,
    input logic [31:0] y);
    logic ovf;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    if (y == 0) return fn[1] ? x : 32'hFFFF_FFFF;
    case (fn)
      3'b100:  return ovf ? x : 32'(int'(x) / int'(y));
      3'b101:  return x / y;
      3'b110:  return ovf ? 32'h0 : 32'(int'(x) % int'(y));
      default: return x % y;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] fn,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       input logic [4:0] addr,
                       input logic [31:0] exp,
                       input int lat,
                       input bit noise);
    exp_t e;
    int n;
    bit stall_ok;
    tick();
    start = 1'b1; f3 = fn; a = x; b = y; wa = addr;
    #1;
    chk("stall_req", 32'(stall_o), 1);
    e.addr = addr; e.data = exp;
    sb.push_back(e);
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom; wa = ~addr;
    n = 0;
    stall_ok = 1'b1;
    while (reg_we_o !== 1'b1 && n < 40) begin
      if (stall_o !== 1'b1) stall_ok = 1'b0;
      if (noise && n < 20) begin
        start = 1'b1; f3 = 3'b101;
        a = $urandom; b = $urandom_range(1, 9);
      end else start = 1'b0;
      tick();
      n++;
    end
    start = 1'b0;
    e = sb.pop_front();
    if (reg_we_o !== 1'b1) begin
      chk("timeout", 32'(reg_we_o), 1);
    end else begin
      chk("latency", n, lat);
      chk("stall_calc", 32'(stall_ok), 1);
      chk("stall_done", 32'(stall_o), 0);
      chk("wdata", reg_wdata_o, e.data);
      chk("waddr", 32'(reg_waddr_o), 32'(e.addr));
      exp_wr++;
    end
    tick();
    chk("busy_after", 32'(busy_o), 0);
    chk("we_after", 32'(reg_we_o), 0);
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] rx, ry;
    int          rl;

    rst = 1'b1; start = 1'b0; flush = 1'b0;
    f3 = '0; a = '0; b = '0; wa = '0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_we", 32'(reg_we_o), 0);
    chk("rst_waddr", 32'(reg_waddr_o), 0);
    chk("rst_wdata", reg_wdata_o, 0);
    rst = 1'b0;

    do_op(3'b101, 100, 7, 5, 14, 32, 0);
    do_op(3'b100, 32'hFFFF_FFF9, 2, 6, 32'hFFFF_FFFD, 32, 0);
    do_op(3'b110, 32'hFFFF_FFF9, 2, 7, 32'hFFFF_FFFF, 32, 0);
    do_op(3'b111, 32'hFFFF_FFF9, 2, 8, 1, 32, 0);
    do_op(3'b101, 5, 0, 9, 32'hFFFF_FFFF, 0, 0);
    do_op(3'b110, 5, 0, 10, 5, 0, 0);
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 11,
          32'h8000_0000, 0, 0);
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 12,
          0, 0, 0);

    // flush at iteration 10
    tick();
    start = 1'b1; f3 = 3'b101; a = 1000; b = 3; wa = 13;
    tick();
    start = 1'b0;
    repeat (10) tick();
    flush = 1'b1;
    #1;
    chk("flush_we", 32'(reg_we_o), 0);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_idle", 32'(busy_o), 0);
    repeat (40) tick();
    chk("flush_nowrite", wr_cnt, exp_wr);
    do_op(3'b101, 9, 3, 14, 3, 32, 0);

    // start toggled during CALC is ignored
    do_op(3'b101, 1000, 10, 15, 100, 32, 1);

    // reset mid-CALC
    tick();
    start = 1'b1; f3 = 3'b100; a = 77; b = 5; wa = 16;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy_o), 0);
    chk("mrst_we", 32'(reg_we_o), 0);
    chk("mrst_waddr", 32'(reg_waddr_o), 0);
    chk("mrst_wdata", reg_wdata_o, 0);
    chk("mrst_stall", 32'(stall_o), 0);
    repeat (40) tick();
    chk("mrst_nowrite", wr_cnt, exp_wr);

    // start+flush in IDLE: not accepted
    tick();
    start = 1'b1; flush = 1'b1;
    f3 = 3'b101; a = 7; b = 1; wa = 17;
    #1;
    chk("sf_stall", 32'(stall_o), 0);
    tick();
    start = 1'b0; flush = 1'b0;
    #1;
    chk("sf_busy", 32'(busy_o), 0);
    repeat (40) tick();
    chk("sf_nowrite", wr_cnt, exp_wr);

    // flush during DONE kills the write
    tick();
    start = 1'b1; f3 = 3'b101; a = 5; b = 0; wa = 18;
    tick();
    start = 1'b0;
    flush = 1'b1;
    #1;
    chk("fd_we", 32'(reg_we_o), 0);
    chk("fd_wdata", reg_wdata_o, 0);
    tick();
    flush = 1'b0;
    #1;
    chk("fd_busy", 32'(busy_o), 0);
    repeat (3) tick();
    chk("fd_nowrite", wr_cnt, exp_wr);

    for (int i = 0; i < 6; i++) begin
      rf = 3'(4 + $urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom >> $urandom_range(0, 31);
      rl = (ry == 0) ? 0 : 32;
      do_op(rf, rx, ry, 5'(20 + i), model(rf, rx, ry), rl, 0);
    end

    chk("write_count", wr_cnt, exp_wr);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
